// File: rtl/board_ram_pkg.sv
// -----------------------------------------------------------------------------
// board_ram_pkg
// Purpose : Shared definitions for the ultimate tic-tac-toe board storage and
//           its win/draw judge. Holds the cell owner codes, the macro-board
//           result codes, the fixed board geometry and the table of the eight
//           winning lines.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package board_ram_pkg;

    // Fixed geometry: 9 macro boards, each a 3x3 grid of 2-bit cells.
    localparam int BOARD_CELLS = 9;
    localparam int NUM_MACROS  = 9;
    localparam int NUM_LINES   = 8;

    // Owner code stored in every cell; 11 is reserved and never stored.
    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_P1    = 2'b01,
        CELL_P2    = 2'b10,
        CELL_RSVD  = 2'b11
    } cell_e;

    // Result of one 3x3 board.
    typedef enum logic [1:0] {
        ST_OPEN = 2'b00,
        ST_P1   = 2'b01,
        ST_P2   = 2'b10,
        ST_DRAW = 2'b11
    } state_e;

    // One 3x3 board flattened row-major; cell k (0-based) sits at bits [2k+1:2k].
    typedef logic [BOARD_CELLS-1:0][1:0] board_t;

    // Winning lines as 0-based cell indices: three rows, three columns, two diagonals.
    localparam int WIN_LINES [NUM_LINES][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    // External addresses are 1-based; only 1..9 name a real board or cell.
    function automatic logic addrInRange(input logic [3:0] addr);
        return (addr >= 4'd1) && (addr <= 4'd9);
    endfunction

endpackage

// File: rtl/board_ram_judge.sv
// -----------------------------------------------------------------------------
// board_judge
// Purpose : Purely combinational evaluation of one 3x3 board. Reports which
//           player owns a complete line, or a draw when every cell is taken
//           with no line, otherwise open. Player 1 has priority when both
//           players own a line, which only happens in illegal positions but
//           keeps the output defined. Written against board_t so it can be
//           reused for the macro-level board later.
// Ports   : board_i  in  18  flattened 3x3 board, cell k at bits [2k+1:2k]
//           state_o  out  2  00 open, 01 P1 won, 10 P2 won, 11 draw
// -----------------------------------------------------------------------------
import board_ram_pkg::*;

module board_judge (
    input  board_t      board_i,
    output logic [1:0]  state_o
);

    logic p1Win;
    logic p2Win;
    logic boardFull;

    // Scan the eight lines for a uniform owner and check whether any cell is still empty.
    always_comb begin
        p1Win     = 1'b0;
        p2Win     = 1'b0;
        boardFull = 1'b1;
        for (int l = 0; l < NUM_LINES; l++) begin
            if ((board_i[WIN_LINES[l][0]] == CELL_P1) &&
                (board_i[WIN_LINES[l][1]] == CELL_P1) &&
                (board_i[WIN_LINES[l][2]] == CELL_P1)) begin
                p1Win = 1'b1;
            end
            if ((board_i[WIN_LINES[l][0]] == CELL_P2) &&
                (board_i[WIN_LINES[l][1]] == CELL_P2) &&
                (board_i[WIN_LINES[l][2]] == CELL_P2)) begin
                p2Win = 1'b1;
            end
        end
        for (int c = 0; c < BOARD_CELLS; c++) begin
            if (board_i[c] == CELL_EMPTY) begin
                boardFull = 1'b0;
            end
        end
    end

    // A win outranks a full board, and P1 outranks P2.
    always_comb begin
        if (p1Win) begin
            state_o = ST_P1;
        end else if (p2Win) begin
            state_o = ST_P2;
        end else if (boardFull) begin
            state_o = ST_DRAW;
        end else begin
            state_o = ST_OPEN;
        end
    end

endmodule

// File: rtl/board_ram.sv
// -----------------------------------------------------------------------------
// board_ram
// Purpose : Flip-flop storage for the 81 cells of the ultimate tic-tac-toe
//           board, with a registered read port and a combinational win/draw
//           result for the addressed macro board.
// Ports   : clock       in  1  rising-edge clock
//           reset       in  1  synchronous active-high, clears all cells and q
//           we          in  1  write enable for cell [addr_macro][addr_micro]
//           data        in  2  owner code to write (11 is ignored)
//           addr_macro  in  4  macro board index, valid 1..9
//           addr_micro  in  4  cell index within the macro board, valid 1..9
//           q           out 2  registered read of the addressed cell
//           state       out 2  result of macro board addr_macro (00 if out of range)
// -----------------------------------------------------------------------------
import board_ram_pkg::*;

module board_ram (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  data,
    input  logic [3:0]  addr_macro,
    input  logic [3:0]  addr_micro,
    output logic [1:0]  q,
    output logic [1:0]  state
);

    board_t [NUM_MACROS-1:0] cellsQ;
    board_t [NUM_MACROS-1:0] cellsD;
    logic [1:0]              qQ;
    logic [1:0]              qD;
    logic                    writeEn;
    board_t                  selBoard;

    // A write only lands when both addresses name a real cell and the code is storable.
    assign writeEn = we && addrInRange(addr_macro) && addrInRange(addr_micro) &&
                     (data != CELL_RSVD);

    // Next cell contents: unchanged except for the single addressed cell on a valid write.
    always_comb begin
        cellsD = cellsQ;
        for (int m = 0; m < NUM_MACROS; m++) begin
            for (int c = 0; c < BOARD_CELLS; c++) begin
                if (writeEn && (addr_macro == 4'(m + 1)) && (addr_micro == 4'(c + 1))) begin
                    cellsD[m][c] = data;
                end
            end
        end
    end

    // Read from the next-state array so a same-cell write is seen immediately;
    // an out-of-range address matches nothing and reads as empty.
    always_comb begin
        qD = CELL_EMPTY;
        for (int m = 0; m < NUM_MACROS; m++) begin
            for (int c = 0; c < BOARD_CELLS; c++) begin
                if ((addr_macro == 4'(m + 1)) && (addr_micro == 4'(c + 1))) begin
                    qD = cellsD[m][c];
                end
            end
        end
    end

    // The judge looks only at stored cells, so a result appears the cycle after its write.
    always_comb begin
        selBoard = '0;
        for (int m = 0; m < NUM_MACROS; m++) begin
            if (addr_macro == 4'(m + 1)) begin
                selBoard = cellsQ[m];
            end
        end
    end

    // Reset clears the whole board in one cycle and takes precedence over any write.
    always_ff @(posedge clock) begin
        if (reset) begin
            cellsQ <= '0;
            qQ     <= CELL_EMPTY;
        end else begin
            cellsQ <= cellsD;
            qQ     <= qD;
        end
    end

    assign q = qQ;

    board_judge uJudge (
        .board_i (selBoard),
        .state_o (state)
    );

endmodule

// File: tb/tb_board_ram.sv
// -----------------------------------------------------------------------------
// tb_board_ram
// Purpose : Directed self-checking bench for board_ram. Inputs change on the
//           falling edge, outputs are sampled 1 time unit after the rising
//           edge, and every expectation is a hand-computed constant.
// Ports   : none (top-level bench)
// -----------------------------------------------------------------------------
module tb_board_ram;

    logic       clock;
    logic       reset;
    logic       we;
    logic [1:0] data;
    logic [3:0] addrMacro;
    logic [3:0] addrMicro;
    logic [1:0] q;
    logic [1:0] state;

    int compared   = 0;
    int mismatched = 0;

    board_ram dut (
        .clock      (clock),
        .reset      (reset),
        .we         (we),
        .data       (data),
        .addr_macro (addrMacro),
        .addr_micro (addrMicro),
        .q          (q),
        .state      (state)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Safety net so the run always ends even if something stalls.
    initial begin
        #200000;
        $error("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] aborted");
    end

    // Drive one cycle of inputs on the falling edge, then step just past the next rising edge.
    task automatic applyStimulus(input logic rstIn, input logic weIn, input logic [1:0] dataIn,
                                 input logic [3:0] macroIn, input logic [3:0] microIn);
        @(negedge clock);
        reset     = rstIn;
        we        = weIn;
        data      = dataIn;
        addrMacro = macroIn;
        addrMicro = microIn;
        @(posedge clock);
        #1;
    endtask

    // One comparison: count it, and report tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    logic [1:0] fillData [9];

    initial begin
        fillData = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        reset     = 1'b1;
        we        = 1'b0;
        data      = 2'b00;
        addrMacro = 4'd1;
        addrMicro = 4'd1;

        // Reset, then every cell reads empty and every macro board is open.
        applyStimulus(1'b1, 1'b0, 2'b00, 4'd1, 4'd1);
        applyStimulus(1'b1, 1'b0, 2'b00, 4'd1, 4'd1);
        checkOutput("reset_q", q, 2'b00);
        for (int m = 1; m <= 9; m++) begin
            for (int c = 1; c <= 9; c++) begin
                applyStimulus(1'b0, 1'b0, 2'b00, 4'(m), 4'(c));
                checkOutput($sformatf("init_q_%0d_%0d", m, c), q, 2'b00);
            end
            checkOutput($sformatf("init_state_%0d", m), state, 2'b00);
        end

        // P1 top row of macro 2.
        applyStimulus(1'b0, 1'b1, 2'b01, 4'd2, 4'd1);
        applyStimulus(1'b0, 1'b1, 2'b01, 4'd2, 4'd2);
        checkOutput("p1_two_cells_open", state, 2'b00);
        applyStimulus(1'b0, 1'b1, 2'b01, 4'd2, 4'd3);
        checkOutput("p1_row_state", state, 2'b01);
        checkOutput("p1_row_wthru_q", q, 2'b01);
        applyStimulus(1'b0, 1'b0, 2'b00, 4'd1, 4'd1);
        checkOutput("macro1_open", state, 2'b00);
        applyStimulus(1'b0, 1'b0, 2'b00, 4'd2, 4'd2);
        checkOutput("p1_q_2_2", q, 2'b01);
        checkOutput("p1_state_2", state, 2'b01);

        // P2 anti-diagonal of macro 5 and middle column of macro 7.
        applyStimulus(1'b0, 1'b1, 2'b10, 4'd5, 4'd3);
        applyStimulus(1'b0, 1'b1, 2'b10, 4'd5, 4'd5);
        applyStimulus(1'b0, 1'b1, 2'b10, 4'd5, 4'd7);
        applyStimulus(1'b0, 1'b0, 2'b00, 4'd5, 4'd1);
        checkOutput("p2_diag_state", state, 2'b10);
        checkOutput("p2_diag_empty_q", q, 2'b00);
        applyStimulus(1'b0, 1'b1, 2'b10, 4'd7, 4'd2);
        applyStimulus(1'b0, 1'b1, 2'b10, 4'd7, 4'd5);
        checkOutput("p2_col_two_open", state, 2'b00);
        applyStimulus(1'b0, 1'b1, 2'b10, 4'd7, 4'd8);
        checkOutput("p2_col_state", state, 2'b10);

        // Fill macro 4 with no completed line: open until the ninth cell, then draw.
        for (int c = 1; c <= 8; c++) begin
            applyStimulus(1'b0, 1'b1, fillData[c-1], 4'd4, 4'(c));
        end
        checkOutput("fill_eight_open", state, 2'b00);
        applyStimulus(1'b0, 1'b1, fillData[8], 4'd4, 4'd9);
        checkOutput("fill_draw_state", state, 2'b11);
        applyStimulus(1'b0, 1'b0, 2'b00, 4'd4, 4'd5);
        checkOutput("fill_q_4_5", q, 2'b10);
        checkOutput("fill_draw_hold", state, 2'b11);

        // Writes that must be ignored.
        applyStimulus(1'b0, 1'b1, 2'b01, 4'd0, 4'd1);
        checkOutput("oor_macro0_q", q, 2'b00);
        checkOutput("oor_macro0_state", state, 2'b00);
        applyStimulus(1'b0, 1'b1, 2'b01, 4'd10, 4'd1);
        checkOutput("oor_macro10_q", q, 2'b00);
        checkOutput("oor_macro10_state", state, 2'b00);
        applyStimulus(1'b0, 1'b1, 2'b01, 4'd3, 4'd0);
        checkOutput("oor_micro0_q", q, 2'b00);
        applyStimulus(1'b0, 1'b1, 2'b11, 4'd3, 4'd3);
        checkOutput("rsvd_data_q", q, 2'b00);
        for (int m = 1; m <= 9; m++) begin
            if (m == 1 || m == 3 || m == 6 || m == 8) begin
                for (int c = 1; c <= 9; c++) begin
                    applyStimulus(1'b0, 1'b0, 2'b00, 4'(m), 4'(c));
                    checkOutput($sformatf("ignored_q_%0d_%0d", m, c), q, 2'b00);
                end
                checkOutput($sformatf("ignored_state_%0d", m), state, 2'b00);
            end
        end

        // Read-during-write returns the new value on the same edge.
        applyStimulus(1'b0, 1'b1, 2'b10, 4'd9, 4'd9);
        checkOutput("rdw_q_9_9", q, 2'b10);
        checkOutput("rdw_state_9", state, 2'b00);
        applyStimulus(1'b0, 1'b0, 2'b00, 4'd9, 4'd9);
        checkOutput("rdw_hold_q", q, 2'b10);

        // Reset with a write pending mid-game: board cleared, write suppressed.
        applyStimulus(1'b1, 1'b1, 2'b01, 4'd1, 4'd1);
        checkOutput("rst_we_q", q, 2'b00);
        for (int m = 1; m <= 9; m++) begin
            for (int c = 1; c <= 9; c++) begin
                applyStimulus(1'b0, 1'b0, 2'b00, 4'(m), 4'(c));
                checkOutput($sformatf("rst_q_%0d_%0d", m, c), q, 2'b00);
            end
            checkOutput($sformatf("rst_state_%0d", m), state, 2'b00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
